// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the synchronous FIFO and its bench.
package fifo_pkg;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    function automatic int FIFO_PTR_W(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port register array: synchronous write, registered read-first read port.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rdata_r;

    // Storage write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read register; sampling the old word on a collision gives read-before-write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_r <= '0;
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count, level flags and optional sticky error flags.
// Define FIFO_ERR_EN to build the overflow/underflow registers.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         wr,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         rd_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [FIFO_PTR_W(DEPTH)-1:0] count,
    output logic                         overflow,
    output logic                         underflow,
    input  logic                         err_clr
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam int PTR_W  = FIFO_PTR_W(DEPTH);
    localparam int CNT_W  = PTR_W;

    logic [PTR_W-1:0] w_ptr_r;
    logic [PTR_W-1:0] r_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             af_r;
    logic             ae_r;
    logic             rd_valid_r;
    logic             wr_acc_s;
    logic             rd_acc_s;
    logic             unused_bits_s;

    // Accept decisions and next occupancy.
    always_comb begin
        wr_acc_s = wr & (~full_r | rd);
        rd_acc_s = rd & ~empty_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1'b1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1'b1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, count and all level flags move together on one edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_ptr_r    <= '0;
            r_ptr_r    <= '0;
            count_r    <= '0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            af_r       <= 1'b0;
            ae_r       <= 1'b1;
            rd_valid_r <= 1'b0;
        end else begin
            w_ptr_r    <= wr_acc_s ? w_ptr_r + PTR_W'(1'b1) : w_ptr_r;
            r_ptr_r    <= rd_acc_s ? r_ptr_r + PTR_W'(1'b1) : r_ptr_r;
            count_r    <= count_nxt_s;
            full_r     <= (count_nxt_s == CNT_W'(DEPTH));
            empty_r    <= (count_nxt_s == CNT_W'(0));
            af_r       <= (count_nxt_s >= CNT_W'(AF_LEVEL));
            ae_r       <= (count_nxt_s <= CNT_W'(AE_LEVEL));
            rd_valid_r <= rd_acc_s;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk    (clk),
        .reset_n(reset_n),
        .we     (wr_acc_s),
        .waddr  (w_ptr_r[ADDR_W-1:0]),
        .wdata  (wr_data),
        .re     (rd_acc_s),
        .raddr  (r_ptr_r[ADDR_W-1:0]),
        .rdata  (rd_data)
    );

`ifdef FIFO_ERR_EN
    logic overflow_r;
    logic underflow_r;

    // Sticky error flags; a new error outranks a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr & full_r & ~rd) begin
                overflow_r <= 1'b1;
            end else if (err_clr) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
            if (rd & empty_r) begin
                underflow_r <= 1'b1;
            end else if (err_clr) begin
                underflow_r <= 1'b0;
            end else begin
                underflow_r <= underflow_r;
            end
        end
    end

    assign overflow  = overflow_r;
    assign underflow = underflow_r;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    // Wrap bits only matter for pointer arithmetic; occupancy comes from count.
    assign unused_bits_s = &{1'b0, err_clr, w_ptr_r[ADDR_W], r_ptr_r[ADDR_W]};

    assign count        = count_r;
    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = af_r;
    assign almost_empty = ae_r;
    assign rd_valid     = rd_valid_r;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (DEPTH=8, AF_LEVEL=6, AE_LEVEL=2).
module tb_sync_fifo;
    import fifo_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CNT_W = FIFO_PTR_W(DEPTH);
`ifdef FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic             clk;
    logic             reset_n;
    logic             wr;
    logic [WIDTH-1:0] wr_data;
    logic             rd;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;
    logic             err_clr;

    int vectors     = 0;
    int miscompares = 0;

    sync_fifo #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .AF_LEVEL(6),
        .AE_LEVEL(2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr          (wr),
        .wr_data     (wr_data),
        .rd          (rd),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Occupancy and the four level flags for an expected count n.
    task automatic chk_occ(input string tag, input int n);
        chk({tag, "_count"}, 32'(count), 32'(n));
        chk({tag, "_full"}, 32'(full), 32'(n == 8));
        chk({tag, "_empty"}, 32'(empty), 32'(n == 0));
        chk({tag, "_afull"}, 32'(almost_full), 32'(n >= 6));
        chk({tag, "_aempty"}, 32'(almost_empty), 32'(n <= 2));
    endtask

    task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic ec);
        wr      = w;
        rd      = r;
        wr_data = d;
        err_clr = ec;
        @(posedge clk);
        #1;
        wr      = 1'b0;
        rd      = 1'b0;
        err_clr = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        wr      = 1'b0;
        rd      = 1'b0;
        wr_data = 8'h00;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_occ("rst", 0);
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_unf", 32'(underflow), 32'h0);
        reset_n = 1'b1;

        // 1: fill to full
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 1'b0, 8'(i), 1'b0);
            chk_occ("t1_wr", i);
        end

        // 2: write while full is dropped, then drain in order
        cyc(1'b1, 1'b0, 8'hFF, 1'b0);
        chk_occ("t2_drop", 8);
        chk("t2_ovf", 32'(overflow), 32'(ERR_EN));
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 1'b1, 8'h00, 1'b0);
            chk("t2_rd_data", 32'(rd_data), 32'(i));
            chk("t2_rd_valid", 32'(rd_valid), 32'h1);
            chk_occ("t2_rd", 8 - i);
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("t2_idle_valid", 32'(rd_valid), 32'h0);
        chk("t2_idle_hold", 32'(rd_data), 32'h08);

        // 3: wr+rd while empty accepts only the write
        cyc(1'b1, 1'b1, 8'hA5, 1'b0);
        chk_occ("t3_wrrd", 1);
        chk("t3_rd_valid", 32'(rd_valid), 32'h0);
        chk("t3_rd_hold", 32'(rd_data), 32'h08);
        chk("t3_unf", 32'(underflow), 32'(ERR_EN));
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk("t3_rd_data", 32'(rd_data), 32'hA5);
        chk("t3_rd_valid2", 32'(rd_valid), 32'h1);
        chk_occ("t3_rd", 0);

        // error flag clear, and set winning over a coincident clear
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("clr_ovf", 32'(overflow), 32'h0);
        chk("clr_unf", 32'(underflow), 32'h0);
        cyc(1'b0, 1'b1, 8'h00, 1'b1);
        chk("setwins_unf", 32'(underflow), 32'(ERR_EN));
        chk("setwins_valid", 32'(rd_valid), 32'h0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("clr2_unf", 32'(underflow), 32'h0);

        // 4: full with simultaneous wr+rd for 3 cycles
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 1'b0, 8'(i), 1'b0);
        end
        chk_occ("t4_fill", 8);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b1, 8'(8'h10 + k), 1'b0);
            chk("t4_rd_data", 32'(rd_data), 32'(1 + k));
            chk("t4_rd_valid", 32'(rd_valid), 32'h1);
            chk_occ("t4_both", 8);
        end
        chk("t4_no_ovf", 32'(overflow), 32'h0);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b1, 8'h00, 1'b0);
            chk("t4_drain", 32'(rd_data), (k < 5) ? 32'(4 + k) : 32'(8'h10 + k - 5));
        end
        chk_occ("t4_empty", 0);

        // 5: 20 writes / 20 reads across the wrap point
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        end
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, 1'b1, 8'(8'h44 + k), 1'b0);
            chk("t5_stream", 32'(rd_data), 32'(8'h40 + k));
            chk_occ("t5_stream", 4);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b1, 8'h00, 1'b0);
            chk("t5_tail", 32'(rd_data), 32'(8'h50 + k));
            chk_occ("t5_tail", 3 - k);
        end

        // 6: asynchronous reset with content present
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
        end
        chk_occ("t6_pre", 5);
        chk("t6_pre_unf", 32'(underflow), 32'(ERR_EN));
        #2 reset_n = 1'b0;
        #1;
        chk_occ("t6_rst", 0);
        chk("t6_rst_rd_data", 32'(rd_data), 32'h0);
        chk("t6_rst_valid", 32'(rd_valid), 32'h0);
        chk("t6_rst_unf", 32'(underflow), 32'h0);
        chk("t6_rst_ovf", 32'(overflow), 32'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk("t6_post_valid", 32'(rd_valid), 32'h0);
        chk("t6_post_data", 32'(rd_data), 32'h0);
        chk_occ("t6_post", 0);
        chk("t6_post_unf", 32'(underflow), 32'(ERR_EN));
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("t6_clr_unf", 32'(underflow), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
